// File: rtl/timer_dev.sv
// Memory-mapped countdown timer with CTRL/PRESET/COUNT registers and a maskable IRQ.
// The CPU write port overrides any FSM update made to CTRL in the same cycle.
module timer_dev #(
  parameter logic [31:0] PRESET_RST = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  state_t      r_state;
  logic [3:0]  r_ctrl;
  logic [31:0] r_preset;
  logic [31:0] r_count;
  logic        r_irq_flag;

  logic        w_wr_ctrl;
  logic        w_wr_preset;
  logic        w_unused_addr;

  assign w_wr_ctrl     = WE & (Addr[3:2] == 2'd0);
  assign w_wr_preset   = WE & (Addr[3:2] == 2'd1);
  assign w_unused_addr = ^{Addr[31:4], Addr[1:0]};

  // FSM and register file; CPU writes come last so they win over FSM updates
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_ctrl     <= 4'd0;
      r_preset   <= PRESET_RST;
      r_count    <= 32'd0;
      r_irq_flag <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_ctrl[0]) begin
            r_irq_flag <= 1'b0;
            r_state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_count <= r_preset;
          r_state <= ST_CNT;
        end
        ST_CNT: begin
          if (!r_ctrl[0]) begin
            r_state <= ST_IDLE;
          end else if (r_count > 32'd1) begin
            r_count <= r_count - 32'd1;
          end else begin
            // COUNT of 0 expires immediately, same as 1
            r_count    <= 32'd0;
            r_irq_flag <= 1'b1;
            r_state    <= ST_INT;
          end
        end
        ST_INT: begin
          if (r_ctrl[2:1] == 2'd1) begin
            r_irq_flag <= 1'b0;
          end else begin
            r_ctrl[0] <= 1'b0;
          end
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_wr_ctrl) begin
        r_ctrl <= Din[3:0];
      end
      if (w_wr_preset) begin
        r_preset <= Din;
      end
    end
  end

  // Zero-latency read mux
  always_comb begin
    Dout = 32'd0;
    case (Addr[3:2])
      2'd0:    Dout = {28'd0, r_ctrl};
      2'd1:    Dout = r_preset;
      2'd2:    Dout = r_count;
      default: Dout = 32'd0;
    endcase
  end

  assign IRQ = r_irq_flag & r_ctrl[3];

endmodule
